reg_wb_queue: RTL
=================

# reg_wb_queue

In-order writeback queue that sits directly upstream of the 8×8-bit register file and drives its four write ports. It accepts up to two register-write results per cycle from the execute stage and buffers them in a FIFO. Each cycle it retires up to four buffered writes onto `wen0..3`/`waddr0..3`/`wdata0..3`, and never presents two writes to the same register in one cycle. A pending-write lookup port lets decode stall on read-after-write hazards.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `CW`, 4: count width, equal to $clog2(DEPTH)+1.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_valid`  in  1  write request 0 (older of the pair).
- `in0_addr`  in  3  register index for request 0.
- `in0_data`  in  8  data for request 0.
- `in1_valid`, `in1_addr`, `in1_data`  in  1/3/8  write request 1 (younger).
- `in_ready`  out  1  high when free entries ≥ 2.
- `wen0..wen3`  out  1 each  register-file write enables.
- `waddr0..waddr3`  out  3 each  register-file write addresses.
- `wdata0..wdata3`  out  8 each  register-file write data.
- `chk_addr`  in  3  register index to test for a pending write.
- `chk_hit`  out  1  some queued entry targets `chk_addr`.
- `count`  out  CW  occupied entries.
- `ovf`  out  1  sticky overflow flag.

## Operation
- State: entry array (addr, data), `rd_ptr`, `wr_ptr` (mod DEPTH, wrap silently), `count`, `ovf`.
- Enqueue (posedge):
  - Requests are accepted only when `in_ready` = 1.
  - If only one of in0/in1 is valid, it takes one slot.
  - If both are valid, in0 is written at `wr_ptr` and in1 at `wr_ptr+1`.
  - Two requests to the same address in one cycle are legal; order is preserved.
- Overflow:
  - If any `inX_valid` is high while `in_ready` = 0, the request is dropped and `ovf` is set.
  - `ovf` is cleared only by reset.
- Drain group (combinational from current state):
  - Slot k (0..3) shows the entry at `rd_ptr+k`.
  - `wenk` = 1 only if k < `count` and `wen0..wen(k-1)` are all 1.
  - In addition, that entry's addr must differ from the addrs of slots 0..k-1.
  - The group therefore stops at the first duplicate address or the first empty slot.
  - A write with `wenk` = 0 drives `waddrk`/`wdatak` to 0.
- Drain commit: at posedge, `rd_ptr` += n, where n = number of asserted `wen`.
- Occupancy update: `count_next = count + accepted - n`. Both terms use the pre-edge state, so a simultaneous enqueue and drain is legal.
- Bypass: none. An entry enqueued at edge t is first drained at edge t+1.
- `in_ready` = (DEPTH − `count`) ≥ 2, combinational from `count`. It ignores the drain happening in the same cycle.
- `chk_hit` = OR over all occupied entries of (addr == `chk_addr`). Entries being drained this cycle are still counted.
- Reset (async assert, any time including mid-drain):
  - `count`, pointers and `ovf` go to 0.
  - All `wen` go to 0, all `waddr`/`wdata` go to 0.
  - `chk_hit` goes to 0 and `in_ready` goes to 1.
  - Queued entries are discarded; array contents need no reset.

## Timing
- Enqueue-to-register-file latency is 1 cycle minimum.
  - A request sampled at edge t drives `wen` during cycle t..t+1.
  - The register file captures it at edge t+1.
- Throughput:
  - Enqueue: 2 per cycle.
  - Drain: ≤4 per cycle, reduced by duplicate-address splits.
  - A back-to-back stream of distinct addresses never backs up.
- Outputs `wen*`, `waddr*`, `wdata*`, `chk_hit` and `in_ready` depend only on registered state and `chk_addr`. There is no path from `inX_*` to any output.
- Ordering: writes to the same register reach the register file in enqueue order, one per cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `count`=5 → immediately all `wen`=0, `count`=0, `in_ready`=1, `ovf`=0. After release, idle outputs stay 0.
- **Latency and order:** enqueue in0=(2,0x11) and in1=(5,0x22) at edge 0 → during the next cycle `wen0`=`wen1`=1, `waddr0`=2, `wdata0`=0x11, `waddr1`=5, `wdata1`=0x22. `count` returns to 0 after edge 1.
- **Duplicate split:**
  - Stimulus: with drain blocked via a preload, queue addrs 3,4,3,6 with data A,B,C,D.
  - Cycle 1: `wen0`/`wen1` only (3=A, 4=B).
  - Cycle 2: 3=C and 6=D.
  - The register file ends with r3=C.
- **Full / overflow:**
  - Reach `count`=7 with DEPTH=8 → `in_ready`=0.
  - Driving `in0_valid`=1 then leaves `count` unchanged and sets `ovf`=1, which stays 1 until reset.
- **Wrap-around:** run 40 random distinct-address pairs → pointers wrap ≥4 times. A scoreboard matches every write in order, with no loss or duplication.
- **Hazard lookup:** enqueue (7,0x5A) → `chk_addr`=7 gives `chk_hit`=1 until the edge that drains it, then 0. `chk_addr`=1 stays 0 throughout.

Source files
------------

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback FIFO in front of an 8x8-bit register file.
// Accepts up to two writes per cycle. Retires up to four per cycle, and never
// retires two writes to the same register in one cycle. A lookup port reports
// pending writes so that decode can detect read-after-write hazards.
module reg_wb_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    input  logic [2:0]    in0_addr,
    input  logic [7:0]    in0_data,
    input  logic          in1_valid,
    input  logic [2:0]    in1_addr,
    input  logic [7:0]    in1_data,
    output logic          in_ready,
    output logic          wen0,
    output logic          wen1,
    output logic          wen2,
    output logic          wen3,
    output logic [2:0]    waddr0,
    output logic [2:0]    waddr1,
    output logic [2:0]    waddr2,
    output logic [2:0]    waddr3,
    output logic [7:0]    wdata0,
    output logic [7:0]    wdata1,
    output logic [7:0]    wdata2,
    output logic [7:0]    wdata3,
    input  logic [2:0]    chk_addr,
    output logic          chk_hit,
    output logic [CW-1:0] count,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]    r_addr [DEPTH];
    logic [7:0]    r_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          w_ready;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_drop;
    logic [1:0]    w_acc_n;
    logic [AW-1:0] w_in1_ptr;
    logic [3:0]    w_wen;
    logic [2:0]    w_n;
    logic [2:0]    w_slot_addr [4];
    logic [7:0]    w_slot_data [4];
    logic          w_hit;

    // Ready only depends on occupancy, so the same-cycle drain cannot create
    // a combinational path from the execute stage to its own handshake.
    assign w_ready   = (r_count <= CW'(DEPTH - 2));
    assign w_acc0    = in0_valid & w_ready;
    assign w_acc1    = in1_valid & w_ready;
    assign w_drop    = (in0_valid | in1_valid) & ~w_ready;
    assign w_acc_n   = {1'b0, w_acc0} + {1'b0, w_acc1};
    assign w_in1_ptr = w_acc0 ? (r_wr_ptr + AW'(1)) : r_wr_ptr;

    // Drain group: the leading run of occupied slots whose addresses are unique.
    always_comb begin
        logic          v_go;
        logic          v_dup;
        logic [AW-1:0] v_idx;
        w_wen = 4'b0000;
        w_n   = 3'd0;
        v_go  = 1'b1;
        v_dup = 1'b0;
        v_idx = '0;
        for (int k = 0; k < 4; k++) begin
            v_idx          = r_rd_ptr + AW'(k);
            w_slot_addr[k] = r_addr[v_idx];
            w_slot_data[k] = r_data[v_idx];
        end
        for (int k = 0; k < 4; k++) begin
            v_dup = 1'b0;
            for (int j = 0; j < k; j++) begin
                v_dup = v_dup | (w_slot_addr[j] == w_slot_addr[k]);
            end
            v_go     = v_go & (CW'(k) < r_count) & ~v_dup;
            w_wen[k] = v_go;
            w_n      = w_n + {2'b00, v_go};
        end
    end

    // Hazard lookup across every occupied entry, including ones draining now.
    always_comb begin
        logic [AW-1:0] v_idx;
        w_hit = 1'b0;
        v_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_rd_ptr + AW'(k);
            w_hit = w_hit | ((CW'(k) < r_count) & (r_addr[v_idx] == chk_addr));
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_addr[r_wr_ptr] <= in0_addr;
            r_data[r_wr_ptr] <= in0_data;
        end
        if (w_acc1) begin
            r_addr[w_in1_ptr] <= in1_addr;
            r_data[w_in1_ptr] <= in1_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_n);
            r_wr_ptr <= r_wr_ptr + AW'(w_acc_n);
            r_count  <= r_count + CW'(w_acc_n) - CW'(w_n);
            r_ovf    <= r_ovf | w_drop;
        end
    end

    assign wen0     = w_wen[0];
    assign wen1     = w_wen[1];
    assign wen2     = w_wen[2];
    assign wen3     = w_wen[3];
    assign waddr0   = w_wen[0] ? w_slot_addr[0] : 3'd0;
    assign waddr1   = w_wen[1] ? w_slot_addr[1] : 3'd0;
    assign waddr2   = w_wen[2] ? w_slot_addr[2] : 3'd0;
    assign waddr3   = w_wen[3] ? w_slot_addr[3] : 3'd0;
    assign wdata0   = w_wen[0] ? w_slot_data[0] : 8'd0;
    assign wdata1   = w_wen[1] ? w_slot_data[1] : 8'd0;
    assign wdata2   = w_wen[2] ? w_slot_data[2] : 8'd0;
    assign wdata3   = w_wen[3] ? w_slot_data[3] : 8'd0;
    assign in_ready = w_ready;
    assign chk_hit  = w_hit;
    assign count    = r_count;
    assign ovf      = r_ovf;
endmodule
